// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int ITER = 32;
  localparam int CW = $clog2(ITER);
  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  typedef struct packed {
    logic is_div;
    logic neg_res;
    logic neg_rem;
  } ctx_t;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Magnitude extraction on entry and result negation for signed ops.
// Only compiled into muldiv_unit when MULDIV_SIGNED_EN is defined.
module muldiv_sign_fix
  import muldiv_pkg::*;
(
  input  logic        sgn,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] ma,
  output logic [31:0] mb,
  output logic        nres,
  output logic        nrem,
  input  ctx_t        ctx,
  input  logic [63:0] raw,
  output logic [63:0] fixed
);

  logic [31:0] q;
  logic [31:0] r;

  assign ma   = (sgn && a[31]) ? -a : a;
  assign mb   = (sgn && b[31]) ? -b : b;
  assign nres = sgn && (a[31] ^ b[31]);
  assign nrem = sgn && a[31];

  // divide: remainder in upper half, quotient in lower half
  assign q = ctx.neg_res ? -raw[31:0] : raw[31:0];
  assign r = ctx.neg_rem ? -raw[63:32] : raw[63:32];

  assign fixed = ctx.is_div ? {r, q}
               : (ctx.neg_res ? -raw : raw);

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU with HI/LO result registers.
// Signed ops enabled by defining MULDIV_SIGNED_EN.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wd,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [63:0]   acc;
  logic [63:0]   acc_nxt;
  logic [31:0]   mcand;
  ctx_t          ctx;

  logic          is_div_in;
  logic          div0;
  logic [31:0]   ma;
  logic [31:0]   mb;
  logic          nres;
  logic          nrem;
  logic [63:0]   res;

  logic [32:0]   sum;
  logic [32:0]   shl;
  logic [33:0]   trial;
  logic          unused_ok;

  assign is_div_in = (op == OP_DIVU) || (op == OP_DIV);
  assign div0      = is_div_in && (b == 32'd0);

`ifdef MULDIV_SIGNED_EN
  muldiv_sign_fix u_sign_fix (
    .sgn   (op[0]),
    .a     (a),
    .b     (b),
    .ma    (ma),
    .mb    (mb),
    .nres  (nres),
    .nrem  (nrem),
    .ctx   (ctx),
    .raw   (acc_nxt),
    .fixed (res)
  );
`else
  assign ma   = a;
  assign mb   = b;
  assign nres = 1'b0;
  assign nrem = 1'b0;
  assign res  = acc_nxt;
`endif

  assign unused_ok = ^{op[0], trial[32], ctx.neg_res, ctx.neg_rem};

  // acc holds {product} for multiply, {remainder, quotient} for divide
  always_comb begin
    sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mcand} : 33'd0);
    shl   = {acc[63:32], acc[31]};
    trial = {1'b0, shl} - {2'b00, mcand};
    if (ctx.is_div) begin
      if (trial[33])
        acc_nxt = {shl[31:0], acc[30:0], 1'b0};
      else
        acc_nxt = {trial[31:0], acc[30:0], 1'b1};
    end else begin
      acc_nxt = {sum, acc[31:1]};
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (start) state_nxt = div0 ? S_DONE : S_RUN;
      S_RUN:  if (cnt == LAST) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      acc   <= '0;
      mcand <= '0;
      ctx   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            cnt   <= '0;
            ctx   <= '{is_div: is_div_in, neg_res: nres, neg_rem: nrem};
            acc   <= {32'd0, is_div_in ? ma : mb};
            mcand <= is_div_in ? mb : ma;
            if (div0) begin
              hi <= a;
              lo <= DIV0_LO;
            end
          end else begin
            if (hi_we) hi <= wd;
            if (lo_we) lo <= wd;
          end
        end
        S_RUN: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            hi <= res[63:32];
            lo <= res[31:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule
